piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: accepts WIDTH-bit words on a valid/ready

---
 rtl/piso_tx.sv | 105 ++++++++++
 tb/tb_piso_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready word input and a framed 1-bit output.
// Optional even-parity trailer bit is enabled by defining PIS_PARITY_EN.
module piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PIS_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q, parity_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_data;
  logic               accept;
  logic               head_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef PIS_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef PIS_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Serial outputs decode registered state only; in_ready also looks at rst.
  always_comb begin
    head_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    last_data = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    ser_valid = (state_q != IDLE);
    busy      = (state_q != IDLE);
    ser_out   = 1'b0;
    if (state_q == SHIFT) ser_out = head_bit;
`ifdef PIS_PARITY_EN
    if (state_q == PARITY) ser_out = parity_q;
    ser_last = (state_q == PARITY);
`else
    ser_last = last_data;
`endif
    in_ready = ~rst & ((state_q == IDLE) | ser_last);
    accept   = in_valid & in_ready;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef PIS_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      SHIFT: begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_data) begin
`ifdef PIS_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PIS_PARITY_EN
      PARITY:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // Accept is only possible in IDLE or on the frame's last cycle, so it overrides cleanly.
    if (accept) begin
      state_d  = SHIFT;
      shift_d  = data_in;
      cnt_d    = '0;
`ifdef PIS_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are checked
// against a queue of expected serial bits built per accepted word.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       in_valid;
  logic       in_ready_a, ser_out_a, ser_valid_a, ser_last_a, busy_a;
  logic       in_ready_b, ser_out_b, ser_valid_b, ser_last_b, busy_b;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic b; logic last; } sbit_t;
  sbit_t qa[$];
  sbit_t qb[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
    .ser_last(ser_last_a), .busy(busy_a));

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .ser_last(ser_last_b), .busy(busy_b));

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  // One frame: WIDTH data bits in the requested order, then optional parity bit.
  task automatic push_frame(input logic [3:0] d);
    sbit_t e;
    logic par;
    par = ^d;
    for (int i = 0; i < 4; i++) begin
      e.b = d[3 - i];
`ifdef PIS_PARITY_EN
      e.last = 1'b0;
`else
      e.last = (i == 3);
`endif
      qa.push_back(e);
      e.b = d[i];
      qb.push_back(e);
    end
`ifdef PIS_PARITY_EN
    e.b = par;
    e.last = 1'b1;
    qa.push_back(e);
    qb.push_back(e);
`endif
  endtask

  function automatic logic exp_ready();
    return !rst && (qa.size() == 0 || qa[0].last);
  endfunction

  task automatic check_all();
    logic v, o, l;
    v = (qa.size() > 0);
    o = v ? qa[0].b : 1'b0;
    l = v ? qa[0].last : 1'b0;
    chk("a_ser_valid", ser_valid_a, v);
    chk("a_ser_out",   ser_out_a,   o);
    chk("a_ser_last",  ser_last_a,  l);
    chk("a_busy",      busy_a,      v);
    chk("a_in_ready",  in_ready_a,  exp_ready());
    v = (qb.size() > 0);
    o = v ? qb[0].b : 1'b0;
    l = v ? qb[0].last : 1'b0;
    chk("b_ser_valid", ser_valid_b, v);
    chk("b_ser_out",   ser_out_b,   o);
    chk("b_ser_last",  ser_last_b,  l);
    chk("b_busy",      busy_b,      v);
  endtask

  // Called just after a negedge with inputs set; returns whether a word was accepted.
  task automatic tick(output logic acc);
    logic [3:0] d;
    acc = in_valid && exp_ready();
    d   = data_in;
    @(posedge clk);
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
    if (rst) begin
      qa.delete();
      qb.delete();
    end else if (acc) begin
      push_frame(d);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_valid"}, ser_valid_a, 1'b0);
    chk({tag, "_a_out"},   ser_out_a,   1'b0);
    chk({tag, "_a_last"},  ser_last_a,  1'b0);
    chk({tag, "_a_busy"},  busy_a,      1'b0);
    chk({tag, "_a_ready"}, in_ready_a,  1'b0);
    chk({tag, "_b_valid"}, ser_valid_b, 1'b0);
    chk({tag, "_b_ready"}, in_ready_b,  1'b0);
  endtask

  // Async reset asserted between edges, held one more cycle, then released.
  task automatic async_reset();
    logic acc;
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_zero("async_rst");
    qa.delete();
    qb.delete();
    @(negedge clk);
    check_all();
    tick(acc);
    rst = 1'b0;
    #1;
    chk("rel_ready_a", in_ready_a, 1'b1);
    chk("rel_ready_b", in_ready_b, 1'b1);
  endtask

  task automatic send(input logic [3:0] d);
    logic acc;
    data_in  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(acc);
      if (acc) break;
      if (k == 19) chk("send_timeout", 1'b0, 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) tick(acc);
  endtask

  initial begin
    logic acc;
    logic holding;
    rst = 1'b1;
    in_valid = 1'b0;
    data_in = '0;

    // Reset held two cycles, then release.
    @(negedge clk);
    check_zero("rst_hold");
    idle(2);
    rst = 1'b0;
    #1;
    chk("rel_ready_a", in_ready_a, 1'b1);
    chk("rel_ready_b", in_ready_b, 1'b1);
    @(negedge clk);
    check_all();

    // Single word, then drain.
    send(4'b1010);
    idle(7);

    // Back-to-back with in_valid held across the frame boundary.
    data_in = 4'b1010;
    in_valid = 1'b1;
    tick(acc);
    chk("b2b_acc1", acc, 1'b1);
    data_in = 4'b1100;
    for (int k = 0; k < 10 && !acc; k++) tick(acc);
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) tick(acc);
    chk("b2b_acc2", acc, 1'b1);
    in_valid = 1'b0;
    idle(7);

    // Ignored pulses while the frame is in flight.
    send(4'b1100);
    data_in = 4'b0110;
    in_valid = 1'b1;
    tick(acc);
    chk("ignore_1", acc, 1'b0);
    data_in = 4'b0011;
    tick(acc);
    chk("ignore_2", acc, 1'b0);
    in_valid = 1'b0;
    idle(6);

    // Reset during bit 2 of a frame, then a clean word.
    send(4'b1111);
    idle(1);
    async_reset();
    @(negedge clk);
    check_all();
    send(4'b0001);
    idle(6);

    send(4'b1000);
    idle(6);

    // Randomised producer that holds data/valid until accepted.
    holding = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!holding && ($urandom_range(0, 3) != 0)) begin
        data_in  = 4'($urandom);
        in_valid = 1'b1;
        holding  = 1'b1;
      end
      if ($urandom_range(0, 119) == 0) begin
        async_reset();
        @(negedge clk);
        check_all();
        holding = 1'b0;
      end else begin
        tick(acc);
        if (acc) begin
          holding  = 1'b0;
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
